// File: rtl/mont_sq_iter_if.sv
// mont_sq_iter_if: request/response bundle for the iterated Montgomery unit.
//   i_dat_a/i_dat_b/i_mode/i_iter/i_val : request (operands, mode, count, valid)
//   o_rdy                               : unit accepts a request
//   o_dat/o_val/i_rdy                   : result, result valid, downstream ready
//   o_iter_cnt                          : iterations finished for current request
// master = requester side, slave = mont_sq_iter side.
interface mont_sq_iter_if #(
    parameter int unsigned N      = 64,
    parameter int unsigned ITER_W = 32
);
    logic [N-1:0]      i_dat_a;
    logic [N-1:0]      i_dat_b;
    logic              i_mode;
    logic [ITER_W-1:0] i_iter;
    logic              i_val;
    logic              o_rdy;
    logic [N-1:0]      o_dat;
    logic              o_val;
    logic              i_rdy;
    logic [ITER_W-1:0] o_iter_cnt;

    modport master (
        output i_dat_a, i_dat_b, i_mode, i_iter, i_val, i_rdy,
        input  o_rdy, o_dat, o_val, o_iter_cnt
    );

    modport slave (
        input  i_dat_a, i_dat_b, i_mode, i_iter, i_val, i_rdy,
        output o_rdy, o_dat, o_val, o_iter_cnt
    );
endinterface

// File: rtl/mont_sq_iter.sv
// mont_sq_iter: repeated Montgomery squaring (mode 0) or repeated Montgomery
// multiplication by B (mode 1) of an operand held in Montgomery form.
// Each iteration: t = X*Y, m = t*MF mod R, u = (t + m*P) >> N, final subtract.
//   i_clk      : clock, rising edge
//   i_rst      : synchronous active-high reset
//   bus        : mont_sq_iter_if slave (request, result, progress count)
module mont_sq_iter #(
    parameter int unsigned                  NUM_WRDS    = 4,
    parameter int unsigned                  WRD_BITS    = 16,
    parameter logic [NUM_WRDS*WRD_BITS-1:0] P           = 64'hFFFF_FFFF_FFFF_FFC5,
    // Zero selects -P^-1 mod R computed at elaboration (a real factor is always odd).
    parameter logic [NUM_WRDS*WRD_BITS-1:0] MONT_FACTOR = '0,
    parameter int unsigned                  MUL_LAT     = 1,
    parameter int unsigned                  ITER_W      = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    mont_sq_iter_if.slave  bus
);
    localparam int unsigned N  = NUM_WRDS * WRD_BITS;
    localparam int unsigned W2 = 2 * N;

    // Newton iteration for P^-1 mod 2^N; each pass doubles the correct bits.
    function automatic logic [N-1:0] neg_inv(input logic [N-1:0] p);
        logic [N-1:0] x;
        x = p;
        for (int unsigned i = 0; i < 8; i++) begin
            x = x * (N'(2) - p * x);
        end
        return '0 - x;
    endfunction

    localparam logic [N-1:0] MF = (MONT_FACTOR == '0) ? neg_inv(P) : MONT_FACTOR;

    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        MUL0 = 6'b000010,
        MUL1 = 6'b000100,
        MUL2 = 6'b001000,
        RED  = 6'b010000,
        DONE = 6'b100000
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        lat_q, lat_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]      acc_q, acc_d;
    logic [N-1:0]      b_q, b_d;
    logic              mode_q, mode_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [W2-1:0]     t_q, t_d;
    logic [N-1:0]      m_q, m_d;
    logic [N:0]        u_q, u_d;

    logic              lat_last;
    logic [ITER_W-1:0] cnt_inc;
    logic [W2:0]       red_sum;
    logic [N:0]        u_sub;

    assign lat_last = (lat_q == 2'(MUL_LAT - 1));
    // cnt_q < iter_q whenever RED is reached, so this never wraps.
    assign cnt_inc  = cnt_q + ITER_W'(1);
    assign red_sum  = {1'b0, t_q} + (W2 + 1)'(m_q) * (W2 + 1)'(P);
    assign u_sub    = u_q - {1'b0, P};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.i_val) state_d = (bus.i_iter == '0) ? DONE : MUL0;
            MUL0: if (lat_last) state_d = MUL1;
            MUL1: if (lat_last) state_d = MUL2;
            MUL2: if (lat_last) state_d = RED;
            RED:  state_d = (cnt_inc == iter_q) ? DONE : MUL0;
            DONE: if (bus.i_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.o_rdy      = (state_q == IDLE);
        bus.o_val      = (state_q == DONE);
        bus.o_dat      = acc_q;
        bus.o_iter_cnt = cnt_q;
    end

    // Datapath next values
    always_comb begin
        lat_d  = '0;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        b_d    = b_q;
        mode_d = mode_q;
        iter_d = iter_q;
        t_d    = t_q;
        m_d    = m_q;
        u_d    = u_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_val) begin
                    acc_d  = bus.i_dat_a;
                    b_d    = bus.i_dat_b;
                    mode_d = bus.i_mode;
                    iter_d = bus.i_iter;
                    cnt_d  = '0;
                end
            end
            MUL0: begin
                lat_d = lat_last ? '0 : lat_q + 2'd1;
                if (lat_last) t_d = W2'(acc_q) * W2'(mode_q ? b_q : acc_q);
            end
            MUL1: begin
                lat_d = lat_last ? '0 : lat_q + 2'd1;
                if (lat_last) m_d = t_q[N-1:0] * MF;
            end
            MUL2: begin
                lat_d = lat_last ? '0 : lat_q + 2'd1;
                if (lat_last) u_d = (N + 1)'(red_sum >> N);
            end
            RED: begin
                acc_d = (u_q >= {1'b0, P}) ? u_sub[N-1:0] : u_q[N-1:0];
                cnt_d = cnt_inc;
            end
            default: ;
        endcase
    end

    // Control counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lat_q <= '0;
            cnt_q <= '0;
        end else begin
            lat_q <= lat_d;
            cnt_q <= cnt_d;
        end
    end

    // Datapath registers (no reset)
    always_ff @(posedge i_clk) begin
        acc_q  <= acc_d;
        b_q    <= b_d;
        mode_q <= mode_d;
        iter_q <= iter_d;
        t_q    <= t_d;
        m_q    <= m_d;
        u_q    <= u_d;
    end
endmodule

// File: tb/tb_mont_sq_iter.sv
// Directed bench for mont_sq_iter: small instance (P=251, R=256, MUL_LAT=1)
// with hand-computed results, plus a default-parameter instance (MUL_LAT=3)
// checked against a shift-and-add reference of a*b*2^-64 mod P.
module tb_mont_sq_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s, rst_b;
    int   n_assert = 0;
    int   n_fail   = 0;

    localparam logic [63:0] PB = 64'hFFFF_FFFF_FFFF_FFC5;

    mont_sq_iter_if #(.N(8),  .ITER_W(32)) bs();
    mont_sq_iter_if #(.N(64), .ITER_W(32)) bb();

    mont_sq_iter #(
        .NUM_WRDS(1), .WRD_BITS(8), .P(8'd251), .MONT_FACTOR(8'd205),
        .MUL_LAT(1), .ITER_W(32)
    ) dut_s (.i_clk(clk), .i_rst(rst_s), .bus(bs));

    mont_sq_iter #(.MUL_LAT(3)) dut_b (.i_clk(clk), .i_rst(rst_b), .bus(bb));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // a^(2^iter) * R^-(2^iter-1) mod P by repeated (x*x mod P) and 64 halvings mod P
    function automatic logic [63:0] ref_sq(input logic [63:0] a, input int unsigned iter);
        logic [127:0] v;
        logic [64:0]  h;
        v = {64'd0, a};
        for (int unsigned k = 0; k < iter; k++) begin
            v = (v * v) % {64'd0, PB};
            h = v[64:0];
            for (int unsigned j = 0; j < 64; j++) begin
                h = h[0] ? ((h + {1'b0, PB}) >> 1) : (h >> 1);
            end
            v = {63'd0, h};
        end
        return v[63:0];
    endfunction

    // Called at a negedge with the small unit idle and i_rdy=1.
    task automatic s_run(input string tag, input logic mode, input logic [7:0] a,
                         input logic [7:0] b, input int unsigned iter, input logic [7:0] exp);
        int unsigned cyc;
        bs.i_mode = mode; bs.i_dat_a = a; bs.i_dat_b = b; bs.i_iter = iter; bs.i_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bs.i_val = 1'b0;
        cyc = 1;
        while (bs.o_val !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'(iter * 4 + 1));
        chk({tag, "_dat"}, 64'(bs.o_dat), 64'(exp));
        chk({tag, "_cnt"}, 64'(bs.o_iter_cnt), 64'(iter));
        @(negedge clk);
        chk({tag, "_idle"}, 64'({bs.o_val, bs.o_rdy}), 64'd1);
    endtask

    task automatic b_run(input string tag, input logic [63:0] a, input int unsigned iter);
        int unsigned cyc;
        bb.i_mode = 1'b0; bb.i_dat_a = a; bb.i_dat_b = '0; bb.i_iter = iter; bb.i_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bb.i_val = 1'b0;
        cyc = 1;
        while (bb.o_val !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'(iter * 10 + 1));
        chk({tag, "_dat"}, bb.o_dat, ref_sq(a, iter));
        chk({tag, "_cnt"}, 64'(bb.o_iter_cnt), 64'(iter));
        @(negedge clk);
    endtask

    initial begin
        int unsigned cyc;
        rst_s = 1'b1; rst_b = 1'b1;
        bs.i_dat_a = '0; bs.i_dat_b = '0; bs.i_mode = 1'b0; bs.i_iter = '0;
        bs.i_val = 1'b0; bs.i_rdy = 1'b1;
        bb.i_dat_a = '0; bb.i_dat_b = '0; bb.i_mode = 1'b0; bb.i_iter = '0;
        bb.i_val = 1'b0; bb.i_rdy = 1'b1;
        repeat (3) @(negedge clk);
        rst_s = 1'b0; rst_b = 1'b0;

        chk("rst_rdy", 64'(bs.o_rdy), 64'd1);
        chk("rst_val", 64'(bs.o_val), 64'd0);
        chk("rst_cnt", 64'(bs.o_iter_cnt), 64'd0);
        chk("rst_b_rdy", 64'(bb.o_rdy), 64'd1);

        s_run("sq5x1",   1'b0, 8'd5,   8'd0,  1, 8'd5);
        s_run("sq10x3",  1'b0, 8'd10,  8'd0,  3, 8'd25);
        s_run("mul5b7",  1'b1, 8'd5,   8'd7,  1, 8'd7);
        s_run("mul10b15",1'b1, 8'd10,  8'd15, 2, 8'd90);
        s_run("sq250",   1'b0, 8'd250, 8'd0,  1, 8'd201);
        s_run("iter0",   1'b0, 8'd42,  8'd0,  0, 8'd42);

        // Backpressure: A=10 (mont 2), two squares -> 16 -> 80
        bs.i_rdy = 1'b0;
        bs.i_mode = 1'b0; bs.i_dat_a = 8'd10; bs.i_iter = 2; bs.i_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bs.i_val = 1'b0;
        cyc = 1;
        while (bs.o_val !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_lat", 64'(cyc), 64'd9);
        for (int i = 0; i < 10; i++) begin
            chk("bp_val", 64'(bs.o_val), 64'd1);
            chk("bp_dat", 64'(bs.o_dat), 64'd80);
            chk("bp_rdy", 64'(bs.o_rdy), 64'd0);
            @(negedge clk);
        end
        bs.i_rdy = 1'b1;
        @(negedge clk);
        chk("bp_release", 64'({bs.o_val, bs.o_rdy}), 64'd1);

        // i_val held while busy with other operands: ignored, nothing queued
        bs.i_mode = 1'b0; bs.i_dat_a = 8'd5; bs.i_iter = 3; bs.i_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bs.i_dat_a = 8'd42; bs.i_iter = 1;
        cyc = 1;
        while (bs.o_val !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        bs.i_val = 1'b0;
        chk("busy_lat", 64'(cyc), 64'd13);
        chk("busy_dat", 64'(bs.o_dat), 64'd5);
        @(negedge clk);
        chk("busy_idle", 64'({bs.o_val, bs.o_rdy}), 64'd1);
        @(negedge clk);
        chk("busy_noqueue", 64'(bs.o_rdy), 64'd1);

        // Reset during MUL1 of the second iteration
        bs.i_dat_a = 8'd10; bs.i_iter = 3; bs.i_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bs.i_val = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_cnt", 64'(bs.o_iter_cnt), 64'd1);
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        chk("mid_rst_rdy", 64'(bs.o_rdy), 64'd1);
        chk("mid_rst_val", 64'(bs.o_val), 64'd0);
        chk("mid_rst_cnt", 64'(bs.o_iter_cnt), 64'd0);
        s_run("after_rst", 1'b0, 8'd10, 8'd0, 3, 8'd25);

        // Request presented during the reset cycle is dropped
        bs.i_dat_a = 8'd7; bs.i_iter = 1; bs.i_val = 1'b1; rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0; bs.i_val = 1'b0;
        chk("rstreq_rdy", 64'(bs.o_rdy), 64'd1);
        @(negedge clk);
        chk("rstreq_rdy2", 64'(bs.o_rdy), 64'd1);

        // Default parameters, MUL_LAT=3
        b_run("big1",  64'h0123_4567_89AB_CDEF, 1);
        b_run("big2",  64'hFFFF_FFFF_FFFF_FFC4, 7);
        b_run("big3",  64'hDEAD_BEEF_0BAD_F00D, 13);
        b_run("big4",  64'h0000_0000_0000_0001, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
